// File: rtl/clock_pkg.sv
// Shared constants for the digital clock time-field counters.
package clock_pkg;
  localparam int SEC_MOD     = 60;
  localparam int MIN_MOD     = 60;
  localparam int HOUR_MOD    = 24;
  localparam int MONTH_MOD   = 12;
  localparam int DAY_MOD_MAX = 31;
  localparam int BCD_W       = 4;
endpackage

// File: rtl/bin2bcd99.sv
// Combinational 7-bit binary to two BCD digits by shift-add-3.
// Only 0..99 is representable; larger inputs lose the hundreds digit.
module bin2bcd99
  import clock_pkg::*;
(
  input  logic [6:0]       i_bin,
  output logic [BCD_W-1:0] o_tens,
  output logic [BCD_W-1:0] o_ones
);
  // Layout: [14:11] tens, [10:7] ones, [6:0] binary being shifted in.
  logic [14:0] w_sh;

  always_comb begin
    w_sh = {8'd0, i_bin};
    for (int i = 0; i < 7; i++) begin
      if (w_sh[10:7] >= 4'd5) w_sh[10:7] = w_sh[10:7] + 4'd3;
      if (w_sh[14:11] >= 4'd5) w_sh[14:11] = w_sh[14:11] + 4'd3;
      w_sh = w_sh << 1;
    end
  end

  assign o_tens = w_sh[14:11];
  assign o_ones = w_sh[10:7];
endmodule

// File: rtl/mod_counter_ld.sv
// Time-field counter with runtime modulus, up/down, clamped load and BCD output.
// Cascade: tc of one field drives enable of the next.
module mod_counter_ld
  import clock_pkg::*;
#(
  parameter int W       = 7,
  parameter int MAX_MOD = 60,
  parameter int BASE    = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic             up,
  input  logic             load,
  input  logic [W-1:0]     load_val,
  input  logic [W-1:0]     mod_val,
  output logic [W-1:0]     qout,
  output logic             tc,
  output logic             load_err,
  output logic [BCD_W-1:0] bcd_tens,
  output logic [BCD_W-1:0] bcd_ones
);
  localparam logic [W:0] L_BASE = (W+1)'(BASE);
  localparam logic [W:0] L_MAX  = (W+1)'(MAX_MOD);
  localparam logic [W:0] L_ONE  = (W+1)'(1);

  logic [W-1:0] r_q;
  logic         r_err;

  logic [W:0]   w_q;
  logic [W:0]   w_mod;
  logic [W:0]   w_meff;
  logic [W:0]   w_top;
  logic [W:0]   w_ld;
  logic [W-1:0] w_clamp;
  logic         w_clamped;
  logic [W-1:0] w_next;
  logic         w_err_next;
  logic [6:0]   w_bin;

  // One extra bit on every compare so BASE+Meff-1 never wraps.
  assign w_q    = {1'b0, r_q};
  assign w_mod  = {1'b0, mod_val};
  assign w_ld   = {1'b0, load_val};
  assign w_meff = ((w_mod != '0) && (w_mod <= L_MAX)) ? w_mod : L_MAX;
  assign w_top  = L_BASE + w_meff - L_ONE;

  always_comb begin
    w_clamped = (w_ld > w_top) || (w_ld < L_BASE);
    if (w_ld > w_top)       w_clamp = w_top[W-1:0];
    else if (w_ld < L_BASE) w_clamp = L_BASE[W-1:0];
    else                    w_clamp = load_val;
  end

  always_comb begin
    w_next     = r_q;
    w_err_next = 1'b0;
    if (clear) begin
      w_next = L_BASE[W-1:0];
    end else if (load) begin
      w_next     = w_clamp;
      w_err_next = w_clamped;
    end else if (w_q > w_top) begin
      // Modulus shrank under the current count: pull back to the new top.
      w_next = w_top[W-1:0];
    end else if (enable) begin
      if (up) w_next = (w_q == w_top)  ? L_BASE[W-1:0] : r_q + W'(1);
      else    w_next = (w_q == L_BASE) ? w_top[W-1:0]  : r_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q   <= L_BASE[W-1:0];
      r_err <= 1'b0;
    end else begin
      r_q   <= w_next;
      r_err <= w_err_next;
    end
  end

  assign tc = reset & enable & ~clear & ~load & (w_q <= w_top) &
              (up ? (w_q == w_top) : (w_q == L_BASE));

  assign qout     = r_q;
  assign load_err = r_err;
  assign w_bin    = 7'(r_q);

  bin2bcd99 u_bcd (
    .i_bin  (w_bin),
    .o_tens (bcd_tens),
    .o_ones (bcd_ones)
  );
endmodule

// File: tb/tb_mod_counter_ld.sv
// Bench for mod_counter_ld: a seconds-style instance (BASE 0, max 60) and a
// day-style instance (BASE 1, max 31) driven side by side against a modular model.
module tb_mod_counter_ld;
  typedef struct packed {
    logic       rst;
    logic       clr;
    logic       en;
    logic       up;
    logic       ld;
    logic [6:0] lv;
    logic [6:0] mv;
  } in_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  in_t a, b, na, nb;

  logic [6:0] qa, qb;
  logic       tca, tcb, erra, errb;
  logic [3:0] ta, oa, tb_t, ob;

  mod_counter_ld #(.W(7), .MAX_MOD(60), .BASE(0)) u_dut_a (
    .clk(clk), .reset(a.rst), .clear(a.clr), .enable(a.en), .up(a.up),
    .load(a.ld), .load_val(a.lv), .mod_val(a.mv),
    .qout(qa), .tc(tca), .load_err(erra), .bcd_tens(ta), .bcd_ones(oa)
  );

  mod_counter_ld #(.W(7), .MAX_MOD(31), .BASE(1)) u_dut_b (
    .clk(clk), .reset(b.rst), .clear(b.clr), .enable(b.en), .up(b.up),
    .load(b.ld), .load_val(b.lv), .mod_val(b.mv),
    .qout(qb), .tc(tcb), .load_err(errb), .bcd_tens(tb_t), .bcd_ones(ob)
  );

  // Expected record: {qout, tc, load_err, bcd_tens, bcd_ones}
  logic [16:0] exp_a_q[$];
  logic [16:0] exp_b_q[$];
  int total = 0;
  int bad   = 0;
  int ma_q, mb_q;
  bit ma_err, mb_err;

  function automatic logic [16:0] pack_exp(input int q, input bit t, input bit e);
    return {7'(q), t, e, 4'(q / 10), 4'(q % 10)};
  endfunction

  // Count lives in [base, base+meff-1]; stepping is modular arithmetic on the offset.
  function automatic void model(input in_t x, input int base, input int maxm,
                                inout int q, inout bit err, output logic [16:0] e);
    int meff, top, lv;
    bit t;
    meff = (int'(x.mv) >= 1 && int'(x.mv) <= maxm) ? int'(x.mv) : maxm;
    top  = base + meff - 1;
    if (!x.rst) begin
      q   = base;
      err = 1'b0;
      e   = pack_exp(q, 1'b0, 1'b0);
      return;
    end
    t = x.en && !x.clr && !x.ld && (q <= top) && (x.up ? (q == top) : (q == base));
    e = pack_exp(q, t, err);
    err = 1'b0;
    if (x.clr) begin
      q = base;
    end else if (x.ld) begin
      lv = int'(x.lv);
      if (lv > top)       begin q = top;  err = 1'b1; end
      else if (lv < base) begin q = base; err = 1'b1; end
      else                q = lv;
    end else if (q > top) begin
      q = top;
    end else if (x.en) begin
      if (x.up) q = base + (q - base + 1) % meff;
      else      q = base + (q - base + meff - 1) % meff;
    end
  endfunction

  task automatic step(input in_t sa, input in_t sb);
    logic [16:0] e;
    @(posedge clk);
    #1;
    a = sa;
    b = sb;
    model(a, 0, 60, ma_q, ma_err, e);
    exp_a_q.push_back(e);
    model(b, 1, 31, mb_q, mb_err, e);
    exp_b_q.push_back(e);
  endtask

  task automatic check(input string nm, input logic [16:0] exp, input logic [16:0] got);
    total++;
    if (exp !== got) begin
      bad++;
      $display("FAIL %s t=%0t got q=%0d tc=%0b err=%0b bcd=%0d/%0d expected q=%0d tc=%0b err=%0b bcd=%0d/%0d",
               nm, $time, got[16:10], got[9], got[8], got[7:4], got[3:0],
               exp[16:10], exp[9], exp[8], exp[7:4], exp[3:0]);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, one expectation per negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_a_q.size() > 0) check("dut_a", exp_a_q.pop_front(), {qa, tca, erra, ta, oa});
      if (exp_b_q.size() > 0) check("dut_b", exp_b_q.pop_front(), {qb, tcb, errb, tb_t, ob});
    end
  end

  initial begin
    na = '0; na.mv = 7'd60;
    nb = '0; nb.mv = 7'd31;
    a = na; b = nb;
    ma_q = 0; mb_q = 1; ma_err = 0; mb_err = 0;

    repeat (2) step(na, nb);
    na.rst = 1'b1; nb.rst = 1'b1;

    // A: count 58 -> 59 (tc) -> 0.  B: shrink modulus under q=31, then clamped load.
    na.ld = 1'b1; na.lv = 7'd58; nb.ld = 1'b1; nb.lv = 7'd31;
    step(na, nb);
    na.ld = 1'b0; na.en = 1'b1; na.up = 1'b1;
    nb.ld = 1'b0; nb.mv = 7'd30; nb.en = 1'b0;
    step(na, nb);
    step(na, nb);
    nb.ld = 1'b1; nb.lv = 7'd0;
    step(na, nb);
    nb.ld = 1'b0;
    repeat (2) step(na, nb);

    // A: count down from 0 wraps to 59.
    na.ld = 1'b1; na.lv = 7'd0; na.en = 1'b0;
    step(na, nb);
    na.ld = 1'b0; na.en = 1'b1; na.up = 1'b0;
    repeat (3) step(na, nb);

    // A: out-of-range load while enabled.
    na.ld = 1'b1; na.lv = 7'd20; na.en = 1'b0;
    step(na, nb);
    na.en = 1'b1; na.up = 1'b1; na.lv = 7'd75;
    step(na, nb);
    na.ld = 1'b0; na.en = 1'b0;
    repeat (2) step(na, nb);

    // A: illegal modulus falls back to 60, then modulus 24.
    na.ld = 1'b1; na.lv = 7'd0; na.mv = 7'd0;
    step(na, nb);
    na.ld = 1'b0; na.en = 1'b1;
    repeat (62) step(na, nb);
    na.mv = 7'd24;
    repeat (30) step(na, nb);

    // A: async reset while sitting at 37; inputs toggle under reset.
    na.ld = 1'b1; na.lv = 7'd36; na.en = 1'b0; na.mv = 7'd60;
    step(na, nb);
    na.ld = 1'b0; na.en = 1'b1;
    step(na, nb);
    na.rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      na.clr = 1'($urandom_range(0, 1));
      na.ld  = 1'($urandom_range(0, 1));
      na.en  = 1'($urandom_range(0, 1));
      na.lv  = 7'($urandom_range(0, 127));
      step(na, nb);
    end
    na.rst = 1'b1; na.clr = 1'b0; na.ld = 1'b0; na.en = 1'b1;
    repeat (3) step(na, nb);

    // Random phase on both instances.
    for (int i = 0; i < 400; i++) begin
      na.rst = ($urandom_range(0, 49) != 0);
      na.clr = ($urandom_range(0, 19) == 0);
      na.ld  = ($urandom_range(0, 9) == 0);
      na.en  = ($urandom_range(0, 3) != 0);
      na.up  = 1'($urandom_range(0, 1));
      na.lv  = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) na.mv = 7'($urandom_range(0, 70));
      nb.rst = ($urandom_range(0, 49) != 0);
      nb.clr = ($urandom_range(0, 19) == 0);
      nb.ld  = ($urandom_range(0, 9) == 0);
      nb.en  = ($urandom_range(0, 3) != 0);
      nb.up  = 1'($urandom_range(0, 1));
      nb.lv  = 7'($urandom_range(0, 40));
      if ($urandom_range(0, 15) == 0) nb.mv = 7'($urandom_range(0, 40));
      step(na, nb);
    end

    repeat (3) @(negedge clk);
    #1;
    total++;
    if (exp_a_q.size() + exp_b_q.size() != 0) begin
      bad++;
      $display("FAIL drain left=%0d expected=0", exp_a_q.size() + exp_b_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mod_counter_ld.md
Name: mod_counter_ld

Overview:
- Next-generation time-field counter for the digital clock. Replaces fixed-modulus counting with:
  - a runtime-selectable modulus
  - up/down direction
  - synchronous load for time setting
  - a configurable base value (0 or 1)
  - direct BCD outputs
- One instance per field (seconds, minutes, hours, day, month). Instances are cascaded through tc into the next field's enable.

Parameters:
- W, 7, width of qout and the count datapath. Must be ≥ ceil(log2(BASE+MAX_MOD)) and ≤ 7.
- MAX_MOD, 60, largest legal modulus. Also the default when mod_val is out of range. BASE+MAX_MOD-1 must be ≤ 99.
- BASE, 0, lowest count value. 0 for s/min/h; 1 for day/month.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset. Name and position as in the codebase; polarity fixed low.
- clear  in  1  synchronous return to BASE.
- enable  in  1  count enable (cascade input).
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous load strobe.
- load_val  in  W  value to load.
- mod_val  in  W  runtime modulus M.
- qout  out  W  current count.
- tc  out  1  terminal count / borrow, combinational.
- load_err  out  1  registered one-cycle flag: the last load was clamped.
- bcd_tens  out  4  tens digit of qout.
- bcd_ones  out  4  units digit of qout.

Behaviour:
- Effective modulus Meff = mod_val if 1 ≤ mod_val ≤ MAX_MOD, else MAX_MOD. TOP = BASE+Meff-1. All compares are unsigned at W+1 bits, so no overflow occurs.
- Reset (reset=0, async): qout=BASE, load_err=0. tc=0 because enable is ignored while in reset.
- Per rising clk, in strict priority order:
  1. clear=1: qout←BASE, load_err←0.
  2. load=1: qout←clamp(load_val).
     - Values above TOP load TOP; values below BASE load BASE.
     - load_err←1 if clamped, else 0.
     - Load overrides enable in the same cycle; no count occurs and tc is forced 0 that cycle.
  3. qout > TOP (modulus shrank, e.g. day 31 → 30-day month): qout←TOP regardless of enable. load_err←0.
  4. enable=1, up=1: qout←(qout==TOP) ? BASE : qout+1.
  5. enable=1, up=0: qout←(qout==BASE) ? TOP : qout-1.
  6. Otherwise hold. load_err←0 on every non-load clock, so it is a single-cycle pulse.
- tc = enable & ~clear & ~load & (qout ≤ TOP) & (up ? qout==TOP : qout==BASE). It is asserted in the same cycle as the wrapping edge, so the next cascaded stage counts on that edge.
- Meff=1 (TOP==BASE): every enabled cycle asserts tc; qout stays BASE.
- Latency: qout is updated one clk after the command; tc has zero latency. BCD outputs are combinational from qout with zero latency.
- BCD: bcd_tens = qout/10, bcd_ones = qout%10, valid for qout ≤ 99.
- mod_val changes take effect combinationally on TOP and tc. The clamp (step 3) is applied on the next edge.
- Reset asserted mid-count overrides all other inputs immediately. Deassertion is synchronised externally and takes effect at the first clk edge after release.

Decomposition:
- Shared package (clock_pkg): constants SEC_MOD=60, MIN_MOD=60, HOUR_MOD=24, MONTH_MOD=12, DAY_MOD_MAX=31, and BCD digit width 4.
- Sub-module bin2bcd99: combinational 7-bit binary to two BCD digits (valid 0..99), implemented by shift-add-3. Instantiated once.
- The clamp/Meff logic stays inline.

Test Plan:
- Defaults (W=7, MAX_MOD=60, BASE=0), mod_val=60, up=1, enable=1 from 0:
  - 58→59 with tc=1 at 59, then wrap to 0.
  - bcd_tens/ones read 5/9 at 59.
- up=0, enable=1 from 0: qout→59, tc=1 during the cycle qout=0.
  - Then 59→58, tc=0.
- BASE=1, MAX_MOD=31, mod_val=31, qout=31; set mod_val=30 with enable=0:
  - next edge qout=30, tc=0 while qout was 31.
  - load_val=0 → qout=1, load_err=1 for one cycle.
- Defaults, load=1 with load_val=75, enable=1, qout=20:
  - qout=59, load_err=1, tc=0 that cycle.
  - Next clock load_err=0.
- mod_val=0, qout=0, enable=1, up=1: behaves as modulus 60 (wrap at 59).
  - Then mod_val=24: wraps 23→0 with tc=1.
- Async reset: drive reset=0 mid-count at qout=37, between clk edges.
  - qout=0 immediately, load_err=0.
  - With reset held, clear/load/enable toggling has no effect.
